// File: rtl/pic_8259_if.sv
// CPU-side bus of the 8259-style interrupt controller: toggle-handshake I/O port access,
// interrupt-acknowledge handshake, IRQ lines and the INTR/vector return path.
interface pic_8259_if;
   logic [11:0] port;
   logic [15:0] din;
   logic [15:0] dout;
   logic        cpu_iordin;
   logic        cpu_iordout;
   logic        cpu_iowrin;
   logic        cpu_iowrout;
   logic [7:0]  irq;
   logic        cpu_intain;
   logic        cpu_intaout;
   logic [7:0]  vector;
   logic        intr;

   modport master (
      output port, din, cpu_iordin, cpu_iowrin, irq, cpu_intain,
      input  dout, cpu_iordout, cpu_iowrout, cpu_intaout, vector, intr
   );

   modport slave (
      input  port, din, cpu_iordin, cpu_iowrin, irq, cpu_intain,
      output dout, cpu_iordout, cpu_iowrout, cpu_intaout, vector, intr
   );
endinterface

// File: rtl/pic_8259_ctrl.sv
// Single 8259A-compatible interrupt controller: edge-triggered IRR, IMR masking, fixed priority
// against in-service levels, INTA vector return and an ICW1/2/3/4 + OCW1/2/3 programming subset.
module pic_8259_ctrl #(
   parameter logic [11:0] BASE_PORT    = 12'h020,
   parameter logic [7:0]  RESET_VECTOR = 8'h08,
   parameter logic [7:0]  RESET_IMR    = 8'hFF
) (
   input logic       clk,
   input logic       reset_n,
   pic_8259_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ICW2, S_ICW3, S_ICW4} init_state_e;

   init_state_e state_q, state_d;
   logic [7:0]  irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
   logic [4:0]  vbase_q, vbase_d;
   logic [7:0]  irq_prev_q, irq_prev_d;
   logic        rdsel_q, rdsel_d;   // 0 = IRR, 1 = ISR
   logic        aeoi_q, aeoi_d, sngl_q, sngl_d, ic4_q, ic4_d;
   logic        cs_cmd_q, cs_cmd_d, cs_data_q, cs_data_d;
   logic [15:0] dout_q, dout_d;
   logic [7:0]  vector_q, vector_d;
   logic        intr_q, intr_d;
   logic        iordout_q, iordout_d, iowrout_q, iowrout_d, intaout_q, intaout_d;

   logic       iord, iowr, inta, wr_cmd, wr_data, blocked, has_win;
   logic [7:0] wr_byte, irq_rise, req, elig, isr_eoi, rd_byte;
   logic [2:0] win, eoi_lo;

   // NOTE: every value driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      irr_d      = irr_q;
      isr_d      = isr_q;
      imr_d      = imr_q;
      vbase_d    = vbase_q;
      rdsel_d    = rdsel_q;
      aeoi_d     = aeoi_q;
      sngl_d     = sngl_q;
      ic4_d      = ic4_q;
      vector_d   = vector_q;
      irq_prev_d = bus.irq;
      iordout_d  = bus.cpu_iordin;
      iowrout_d  = bus.cpu_iowrin;
      intaout_d  = bus.cpu_intain;
      cs_cmd_d   = (bus.port == BASE_PORT);
      cs_data_d  = (bus.port == BASE_PORT + 12'd1);

      iord    = bus.cpu_iordin ^ iordout_q;
      iowr    = bus.cpu_iowrin ^ iowrout_q;
      inta    = bus.cpu_intain ^ intaout_q;
      wr_byte = bus.port[0] ? bus.din[15:8] : bus.din[7:0];
      wr_cmd  = iowr & cs_cmd_q;
      wr_data = iowr & cs_data_q;

      // A line is eligible only while no equal-or-higher priority level is in service.
      irq_rise = bus.irq & ~irq_prev_q;
      req      = irr_q & ~imr_q;
      blocked  = 1'b0;
      elig     = 8'h00;
      for (int i = 0; i < 8; i++) begin
         blocked = blocked | isr_q[i];
         elig[i] = req[i] & ~blocked;
      end
      has_win = |elig;
      win     = 3'd0;
      eoi_lo  = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (elig[i])  win    = 3'(i);
         if (isr_q[i]) eoi_lo = 3'(i);
      end
      intr_d = has_win;

      // EOI clears first; the INTA winner below was already resolved on the pre-EOI ISR.
      isr_eoi = isr_q;
      if (wr_cmd && !wr_byte[4] && !wr_byte[3]) begin
         case (wr_byte[7:5])
            3'b001:  if (|isr_q) isr_eoi[eoi_lo] = 1'b0;
            3'b011:  isr_eoi[wr_byte[2:0]] = 1'b0;
            default: ;
         endcase
      end
      isr_d = isr_eoi;

      if (inta) begin
         if (has_win) begin
            vector_d   = {vbase_q, win};
            irr_d[win] = 1'b0;
            if (!aeoi_q) isr_d[win] = 1'b1;
         end else begin
            vector_d = {vbase_q, 3'd7};
         end
      end
      irr_d = irr_d | irq_rise;

      if (wr_cmd && !wr_byte[4] && wr_byte[3] && wr_byte[1]) rdsel_d = wr_byte[0];

      if (wr_cmd && wr_byte[4]) begin
         imr_d   = 8'h00;
         isr_d   = 8'h00;
         irr_d   = 8'h00;
         rdsel_d = 1'b0;
         aeoi_d  = 1'b0;
         sngl_d  = wr_byte[1];
         ic4_d   = wr_byte[0];
         state_d = S_ICW2;
      end else if (wr_data) begin
         case (state_q)
            S_IDLE: imr_d = wr_byte;
            S_ICW2: begin
               vbase_d = wr_byte[7:3];
               state_d = !sngl_q ? S_ICW3 : (ic4_q ? S_ICW4 : S_IDLE);
            end
            S_ICW3: state_d = ic4_q ? S_ICW4 : S_IDLE;
            S_ICW4: begin
               aeoi_d  = wr_byte[1];
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Read data is refreshed every cycle; iord only gates the acknowledge toggle.
      if (cs_cmd_q)       rd_byte = rdsel_q ? isr_q : irr_q;
      else if (cs_data_q) rd_byte = imr_q;
      else                rd_byte = 8'hFF;
      dout_d = (iord || !iord) ? {rd_byte, rd_byte} : dout_q;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         irr_q      <= 8'h00;
         isr_q      <= 8'h00;
         imr_q      <= RESET_IMR;
         vbase_q    <= RESET_VECTOR[7:3];
         irq_prev_q <= 8'h00;
         rdsel_q    <= 1'b0;
         aeoi_q     <= 1'b0;
         sngl_q     <= 1'b0;
         ic4_q      <= 1'b0;
         cs_cmd_q   <= 1'b0;
         cs_data_q  <= 1'b0;
         dout_q     <= 16'hFFFF;
         vector_q   <= 8'hFF;
         intr_q     <= 1'b0;
         iordout_q  <= 1'b0;
         iowrout_q  <= 1'b0;
         intaout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         irr_q      <= irr_d;
         isr_q      <= isr_d;
         imr_q      <= imr_d;
         vbase_q    <= vbase_d;
         irq_prev_q <= irq_prev_d;
         rdsel_q    <= rdsel_d;
         aeoi_q     <= aeoi_d;
         sngl_q     <= sngl_d;
         ic4_q      <= ic4_d;
         cs_cmd_q   <= cs_cmd_d;
         cs_data_q  <= cs_data_d;
         dout_q     <= dout_d;
         vector_q   <= vector_d;
         intr_q     <= intr_d;
         iordout_q  <= iordout_d;
         iowrout_q  <= iowrout_d;
         intaout_q  <= intaout_d;
      end
   end

   assign bus.dout        = dout_q;
   assign bus.vector      = vector_q;
   assign bus.intr        = intr_q;
   assign bus.cpu_iordout = iordout_q;
   assign bus.cpu_iowrout = iowrout_q;
   assign bus.cpu_intaout = intaout_q;

endmodule

// File: tb/tb_pic_8259_ctrl.sv
// Directed bench for pic_8259_ctrl: programming, priority, EOI, INTA, AEOI, readback and reset.
module tb_pic_8259_ctrl;

   logic clk = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   pic_8259_if bus ();

   pic_8259_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic io_write(input logic [11:0] a, input logic [7:0] b);
      bus.port = a;
      bus.din  = {b, b};
      tick();
      bus.cpu_iowrin = ~bus.cpu_iowrin;
      tick();
   endtask

   task automatic io_read(input logic [11:0] a, output logic [15:0] d);
      bus.port = a;
      tick();
      bus.cpu_iordin = ~bus.cpu_iordin;
      tick();
      d = bus.dout;
   endtask

   task automatic do_inta(output logic [7:0] v);
      bus.cpu_intain = ~bus.cpu_intain;
      tick();
      v = bus.vector;
      check("inta_ack", {15'd0, bus.cpu_intaout}, {15'd0, bus.cpu_intain});
   endtask

   initial begin
      logic [15:0] rd;
      logic [7:0]  v;

      reset_n        = 1'b0;
      bus.port       = 12'h000;
      bus.din        = 16'h0000;
      bus.cpu_iordin = 1'b0;
      bus.cpu_iowrin = 1'b0;
      bus.cpu_intain = 1'b0;
      bus.irq        = 8'h00;
      tick();
      tick();
      check("rst_dout", bus.dout, 16'hFFFF);
      check("rst_vector", {8'h00, bus.vector}, 16'h00FF);
      check("rst_intr", {15'd0, bus.intr}, 16'h0000);
      check("rst_acks", {13'd0, bus.cpu_iordout, bus.cpu_iowrout, bus.cpu_intaout}, 16'h0000);
      reset_n = 1'b1;
      io_read(12'h021, rd);
      check("rst_imr", rd, 16'hFFFF);
      io_read(12'h020, rd);
      check("rst_irr", rd, 16'h0000);

      // 1: init, single IRQ0, INTA, non-specific EOI
      io_write(12'h020, 8'h13);
      io_write(12'h021, 8'h08);
      io_write(12'h021, 8'h01);
      io_write(12'h021, 8'hFE);
      io_read(12'h021, rd);
      check("t1_imr", rd, 16'hFEFE);
      bus.irq = 8'h01;
      tick();
      check("t1_intr_lag", {15'd0, bus.intr}, 16'h0000);
      tick();
      check("t1_intr", {15'd0, bus.intr}, 16'h0001);
      io_read(12'h020, rd);
      check("t1_irr", rd, 16'h0101);
      do_inta(v);
      check("t1_vector", {8'h00, v}, 16'h0008);
      tick();
      check("t1_intr_clr", {15'd0, bus.intr}, 16'h0000);
      io_write(12'h020, 8'h0B);
      io_read(12'h020, rd);
      check("t1_isr", rd, 16'h0101);
      io_write(12'h020, 8'h20);
      io_read(12'h020, rd);
      check("t1_isr_eoi", rd, 16'h0000);

      // 2: simultaneous irq1/irq3, nesting block, EOI releases irq3
      io_write(12'h021, 8'h00);
      bus.irq = 8'h0A;
      tick();
      tick();
      check("t2_intr", {15'd0, bus.intr}, 16'h0001);
      do_inta(v);
      check("t2_vec1", {8'h00, v}, 16'h0009);
      tick();
      tick();
      check("t2_blocked", {15'd0, bus.intr}, 16'h0000);
      io_write(12'h020, 8'h20);
      tick();
      check("t2_intr_eoi", {15'd0, bus.intr}, 16'h0001);
      do_inta(v);
      check("t2_vec3", {8'h00, v}, 16'h000B);
      io_write(12'h020, 8'h20);
      bus.irq = 8'h00;

      // 3: masked request latches in IRR, unmask raises intr, OCW3 read select
      io_write(12'h021, 8'h04);
      bus.irq = 8'h04;
      tick();
      tick();
      check("t3_masked", {15'd0, bus.intr}, 16'h0000);
      io_write(12'h021, 8'h00);
      tick();
      check("t3_unmask", {15'd0, bus.intr}, 16'h0001);
      io_write(12'h020, 8'h0B);
      io_read(12'h020, rd);
      check("t3_isr", rd, 16'h0000);
      io_write(12'h020, 8'h0A);
      io_read(12'h020, rd);
      check("t3_irr", rd, 16'h0404);
      do_inta(v);
      check("t3_vec2", {8'h00, v}, 16'h000A);
      io_write(12'h020, 8'h20);
      bus.irq = 8'h00;

      // 4: spurious INTA, then AEOI mode
      tick();
      do_inta(v);
      check("t4_spurious", {8'h00, v}, 16'h000F);
      io_write(12'h020, 8'h0B);
      io_read(12'h020, rd);
      check("t4_isr_spur", rd, 16'h0000);
      io_write(12'h020, 8'h13);
      io_write(12'h021, 8'h08);
      io_write(12'h021, 8'h03);
      io_write(12'h021, 8'h00);
      bus.irq = 8'h20;
      tick();
      tick();
      check("t4_intr5", {15'd0, bus.intr}, 16'h0001);
      do_inta(v);
      check("t4_vec5", {8'h00, v}, 16'h000D);
      io_write(12'h020, 8'h0B);
      io_read(12'h020, rd);
      check("t4_isr_aeoi", rd, 16'h0000);

      // 5: ICW1 aborts an init sequence, then async reset with a pending interrupt
      io_write(12'h020, 8'h13);
      io_write(12'h021, 8'h08);
      io_write(12'h020, 8'h13);
      io_write(12'h021, 8'h10);
      io_write(12'h021, 8'h01);
      io_read(12'h021, rd);
      check("t5_imr", rd, 16'h0000);
      bus.irq = 8'h01;
      tick();
      tick();
      do_inta(v);
      check("t5_vec_base", {8'h00, v}, 16'h0010);
      bus.irq = 8'h03;
      io_write(12'h020, 8'h20);
      tick();
      check("t5_pending", {15'd0, bus.intr}, 16'h0001);
      #2;
      reset_n        = 1'b0;
      bus.irq        = 8'h00;
      bus.cpu_iordin = 1'b0;
      bus.cpu_iowrin = 1'b0;
      bus.cpu_intain = 1'b0;
      #1;
      check("t5_rst_intr", {15'd0, bus.intr}, 16'h0000);
      check("t5_rst_vector", {8'h00, bus.vector}, 16'h00FF);
      check("t5_rst_dout", bus.dout, 16'hFFFF);
      tick();
      tick();
      reset_n = 1'b1;
      io_read(12'h021, rd);
      check("t5_rst_imr", rd, 16'hFFFF);

      // 6: reset vector base, nested ISR, specific EOI, IMR readback and read handshake
      io_write(12'h021, 8'h00);
      bus.irq = 8'h08;
      tick();
      tick();
      do_inta(v);
      check("t6_vec3", {8'h00, v}, 16'h000B);
      bus.irq = 8'h09;
      tick();
      tick();
      check("t6_intr0", {15'd0, bus.intr}, 16'h0001);
      do_inta(v);
      check("t6_vec0", {8'h00, v}, 16'h0008);
      io_write(12'h020, 8'h0B);
      io_read(12'h020, rd);
      check("t6_isr", rd, 16'h0909);
      io_write(12'h020, 8'h63);
      io_read(12'h020, rd);
      check("t6_seoi", rd, 16'h0101);
      io_write(12'h021, 8'h5A);
      io_read(12'h021, rd);
      check("t6_imr", rd, 16'h5A5A);
      check("t6_iord_ack", {15'd0, bus.cpu_iordout}, {15'd0, bus.cpu_iordin});
      io_write(12'h020, 8'h20);
      io_read(12'h020, rd);
      check("t6_nseoi", rd, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pic_8259_ctrl.md
Name: pic_8259_ctrl

Overview:
- Interrupt controller and arbiter between the PIT (irq0) and the other IRQ sources on one side and the 286 CPU on the other.
- Latches rising edges on 8 IRQ lines and masks them.
- Resolves fixed priority (IRQ0 highest) against in-service levels.
- Drives INTR and returns the vector on an interrupt-acknowledge handshake.
- Programmed through ports BASE_PORT/BASE_PORT+1 with an 8259A-compatible ICW/OCW subset, on the same toggle I/O handshake as the other peripherals.

Parameters:
BASE_PORT, 12'h020, command port; data/mask port is BASE_PORT+1
RESET_VECTOR, 8'h08, vector base (bits 7:3 used) until ICW2 is written
RESET_IMR, 8'hFF, mask register value after reset

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
port  in  12  I/O address
din  in  16  write data; byte lane selected by port[0] (1 = din[15:8])
dout  out  16  read data, byte replicated on both lanes
cpu_iordin  in  1  read request toggle
cpu_iordout  out  1  read acknowledge toggle
cpu_iowrin  in  1  write request toggle
cpu_iowrout  out  1  write acknowledge toggle
irq  in  8  interrupt request lines, same clock domain; irq[0] from PIT
cpu_intain  in  1  interrupt-acknowledge request toggle
cpu_intaout  out  1  interrupt-acknowledge toggle
vector  out  8  interrupt vector, valid when cpu_intaout == cpu_intain
intr  out  1  interrupt request to CPU

Behaviour:
- Reset (async, all registers):
  - IRR=0, ISR=0, IMR=RESET_IMR, vbase=RESET_VECTOR[7:3], irq_prev=irq sampled as 0.
  - rdsel=IRR, aeoi=0, state=IDLE.
  - dout=16'hFFFF, vector=8'hFF, intr=0, all ack toggles=0.
- Handshake: iord = cpu_iordin^cpu_iordout, iowr likewise, inta likewise. Each ack output is registered to its request input every clk.
- Chip selects cs_cmd/cs_data are registered compares of port (1 cycle). The access is serviced in the cycle the request toggle differs.
- dout, registered every cycle:
  - cs_cmd: IRR or ISR per rdsel.
  - cs_data: IMR.
  - else 8'hFF.
- Edge detect: irq_prev<=irq; edge = irq & ~irq_prev. IRR[n] is set on an edge regardless of IMR. Set wins over a same-cycle clear.
- Init FSM: IDLE, ICW2, ICW3, ICW4.
  - Write cmd with din bit4=1 (ICW1), from any state:
    - IMR=0, ISR=0, IRR=0, rdsel=IRR, aeoi=0; save sngl=bit1, ic4=bit0.
    - Go to ICW2. An in-progress sequence is aborted.
  - ICW2 (data write): vbase=bits7:3. Next state: ICW3 if !sngl, else ICW4 if ic4, else IDLE.
  - ICW3 (data write): ignored, no cascade. Next state: ICW4 if ic4, else IDLE.
  - ICW4 (data write): aeoi=bit1. Next state: IDLE.
  - In IDLE a data write is OCW1: IMR=din byte.
  - Command writes with bit4=0 are accepted in any state.
- OCW2 (cmd, bit4=0, bit3=0):
  - bits7:5=001: non-specific EOI, clears the lowest-numbered set ISR bit.
  - bits7:5=011: specific EOI, clears ISR[bits2:0].
  - Other codes: no-op.
  - EOI with ISR=0: no-op.
- OCW3 (cmd, bit4=0, bit3=1): if bit1=1 then rdsel = bit0 ? ISR : IRR.
- Priority:
  - req = IRR & ~IMR.
  - Line n is eligible if req[n] and ISR[n:0]==0.
  - win = lowest eligible n.
  - intr registered = |eligible, one cycle after the IRR/IMR/ISR change.
- INTA (inta true):
  - With a winner: vector={vbase,win}; IRR[win] cleared; ISR[win] set unless aeoi.
  - No winner (spurious): vector={vbase,3'd7}; no state change.
  - cpu_intaout follows cpu_intain in the same edge, so vector is valid when the toggles match.
- Simultaneous INTA and EOI in one cycle: EOI applies first, then the INTA winner is computed on the pre-EOI ISR. Both commits happen together.
- Writes during INTA: both are processed. ICW1 overrides the IRR/ISR updates.

Test Plan:
1. Reset, then ICW1=0x13, ICW2=0x08, ICW4=0x01, OCW1=0xFE; toggle irq[0] 0->1 -> IRR=0x01, intr=1 after 1 cycle; INTA -> vector=0x08, ISR=0x01, intr=0; OCW2=0x20 -> ISR=0x00.
2. Rising edges on irq3 and irq1 in the same cycle, IMR=0x00 -> INTA returns 0x09, then (no EOI) intr=0 since ISR[1] blocks irq3; EOI -> intr=1, INTA -> 0x0B.
3. IMR=0x04, edge on irq2 -> IRR=0x04, intr=0; OCW1=0x00 -> intr=1 next cycle; OCW3=0x0B then read cmd -> ISR value; OCW3=0x0A -> IRR=0x04.
4. INTA toggle with no eligible request -> vector=0x0F, ISR unchanged; AEOI mode (ICW4=0x03), irq5 edge, INTA -> vector=0x0D, ISR stays 0.
5. ICW1 written mid-sequence (after ICW2, before ICW4) -> sequence restarts, IMR=0; assert reset_n low during pending interrupt -> intr=0, IMR=0xFF, vector base 0x08 asynchronously.
6. Specific EOI OCW2=0x63 with ISR=0x09 -> ISR=0x01; read port 0x21 while IMR=0x5A -> dout=16'h5A5A, cpu_iordout matches cpu_iordin one clock after toggle.
